// File: rtl/kogge_stone_32bit_pkg.sv
// Shared ALU constants and the generate/propagate pair carried through the prefix tree.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package kogge_stone_32bit_pkg;

    // Operand width of the fast add path.
    localparam int KS_WIDTH  = 32;

    // Prefix levels needed to span KS_WIDTH bits: log2(32).
    localparam int KS_LEVELS = 5;

    // Group generate / group propagate pair flowing between prefix cells.
    typedef struct packed {
        logic g;
        logic p;
    } ks_gp_t;

endpackage : kogge_stone_32bit_pkg

// File: rtl/kogge_stone_32bit_prefix_cell.sv
// Black prefix cell: merges a high group (hi_i) with the adjacent lower group (lo_i).
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module ks_prefix_cell
    import kogge_stone_32bit_pkg::*;
(
    input  ks_gp_t hi_i,
    input  ks_gp_t lo_i,
    output ks_gp_t gp_o
);

    // The high group generates, or it propagates a carry generated by the low group.
    assign gp_o.g = hi_i.g | (hi_i.p & lo_i.g);

    // The merged group propagates only if both halves propagate.
    assign gp_o.p = hi_i.p & lo_i.p;

endmodule : ks_prefix_cell

// File: rtl/kogge_stone_32bit.sv
// Registered 32-bit Kogge-Stone adder: {Cout, S} = A + B + Cin.
// Latency: 1 cycle; one new operand set accepted every cycle.
// Backpressure: none; no handshake, outputs overwritten each cycle.
module kogge_stone_32bit
    import kogge_stone_32bit_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KS_WIDTH-1:0] A,
    input  logic [KS_WIDTH-1:0] B,
    input  logic                Cin,
    output logic [KS_WIDTH-1:0] S,
    output logic                Cout
);

    // Group G/P after each prefix level; gp_l0 is the raw per-bit PG stage.
    ks_gp_t [KS_WIDTH-1:0] gp_l0;
    ks_gp_t [KS_WIDTH-1:0] gp_l1;
    ks_gp_t [KS_WIDTH-1:0] gp_l2;
    ks_gp_t [KS_WIDTH-1:0] gp_l3;
    ks_gp_t [KS_WIDTH-1:0] gp_l4;
    ks_gp_t [KS_WIDTH-1:0] gp_l5;

    // c[i] is the carry into bit i; c[KS_WIDTH] is the carry out.
    logic [KS_WIDTH:0]     carry;

    // Final-level propagates are not needed by the sum; collected only to sink them.
    logic [KS_WIDTH-1:0]   p_final;
    logic                  unused_p_final;

    logic [KS_WIDTH-1:0]   s_d;
    logic [KS_WIDTH-1:0]   s_q;
    logic                  cout_d;
    logic                  cout_q;

    // ------------------------------------------------------------------
    // PG generation. Cin is treated as a generate at position -1 and folded
    // straight into bit 0, so every group generate below already includes it.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < KS_WIDTH; i++) begin : g_pg
        assign gp_l0[i].p = A[i] ^ B[i];
        if (i == 0) begin : g_bit0
            assign gp_l0[i].g = (A[i] & B[i]) | ((A[i] ^ B[i]) & Cin);
        end else begin : g_bitn
            assign gp_l0[i].g = A[i] & B[i];
        end
    end

    // ------------------------------------------------------------------
    // Prefix tree: level k combines each bit with the group 2^k positions
    // below it. Bits below the span have already resolved and pass through.
    // Each level gets its own signal so there is no feedback through one array.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < KS_LEVELS; k++) begin : g_level
        ks_gp_t [KS_WIDTH-1:0] lvl_in;
        ks_gp_t [KS_WIDTH-1:0] lvl_out;

        case (k)
            0: begin : g_w0
                assign lvl_in = gp_l0;
                assign gp_l1  = lvl_out;
            end
            1: begin : g_w1
                assign lvl_in = gp_l1;
                assign gp_l2  = lvl_out;
            end
            2: begin : g_w2
                assign lvl_in = gp_l2;
                assign gp_l3  = lvl_out;
            end
            3: begin : g_w3
                assign lvl_in = gp_l3;
                assign gp_l4  = lvl_out;
            end
            default: begin : g_w4
                assign lvl_in = gp_l4;
                assign gp_l5  = lvl_out;
            end
        endcase

        for (genvar i = 0; i < KS_WIDTH; i++) begin : g_bit
            if (i >= (1 << k)) begin : g_cell
                ks_prefix_cell u_cell (
                    .hi_i (lvl_in[i]),
                    .lo_i (lvl_in[i - (1 << k)]),
                    .gp_o (lvl_out[i])
                );
            end else begin : g_pass
                assign lvl_out[i] = lvl_in[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Post-processing: carry into bit i+1 is the group generate G[i:0]
    // (Cin included); each sum bit is its raw propagate XOR its carry-in.
    // ------------------------------------------------------------------
    assign carry[0] = Cin;

    for (genvar i = 0; i < KS_WIDTH; i++) begin : g_sum
        assign carry[i+1] = gp_l5[i].g;
        assign s_d[i]     = gp_l0[i].p ^ carry[i];
        assign p_final[i] = gp_l5[i].p;
    end

    assign cout_d         = carry[KS_WIDTH];
    assign unused_p_final = ^p_final;

    // Output register: synchronous clear drops any in-flight result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;

endmodule : kogge_stone_32bit

// File: tb/tb_kogge_stone_32bit.sv
module tb_kogge_stone_32bit;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic [31:0] S;
    logic        Cout;

    // Set once stimulus starts; the monitor checks one result per edge after that.
    logic        drv_vld;

    logic [32:0] exp_q[$];
    string       name_q[$];

    int checks;
    int errors;

    kogge_stone_32bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .S     (S),
        .Cout  (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand set before the next rising edge and queue its expected result.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c,
                         input logic r, input logic [32:0] exp_val, input string name);
        @(negedge clk);
        A       = a;
        B       = b;
        Cin     = c;
        rst_n   = r;
        drv_vld = 1'b1;
        exp_q.push_back(exp_val);
        name_q.push_back(name);
    endtask

    // Monitor: after each edge that registered stimulus, pop and compare.
    initial begin : monitor
        logic        v;
        logic [32:0] e;
        string       n;
        forever begin
            @(posedge clk);
            v = drv_vld;
            #1;
            if (v) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL underflow: got Cout=%0b S=%08h, required a queued expectation", Cout, S);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    if ({Cout, S} !== e) begin
                        errors++;
                        $display("FAIL %s: got Cout=%0b S=%08h, required Cout=%0b S=%08h",
                                 n, Cout, S, e[32], e[31:0]);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;

        checks  = 0;
        errors  = 0;
        drv_vld = 1'b0;
        rst_n   = 1'b0;
        A       = '0;
        B       = '0;
        Cin     = 1'b0;

        // Reset state with non-zero operands present.
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 33'h0, "reset_state0");
        drive(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 33'h0, "reset_state1");

        // Exhaustive small operands: carry out must stay 0.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    drive(32'(a), 32'(b), c[0], 1'b1, {1'b0, 32'(a + b + c)}, "small");
                end
            end
        end

        // Full carry propagation across all 32 bits.
        drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, {1'b1, 32'h0000_0000}, "ripple_all_ones_b0");
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, {1'b1, 32'hFFFF_FFFF}, "all_ones_both");

        // Alternating patterns: every bit propagates, Cin travels the whole tree.
        drive(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b1, {1'b1, 32'h0000_0000}, "alt_cin1");
        drive(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b1, {1'b0, 32'hFFFF_FFFF}, "alt_cin0");
        drive(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, {1'b1, 32'h0000_0000}, "msb_gen");
        drive(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, {1'b0, 32'h0001_0000}, "span16");
        drive(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, {1'b0, 32'h8000_0000}, "span_to_msb");

        // Reset held for two edges with operands present, then released.
        drive(32'd7, 32'd9, 1'b0, 1'b0, 33'h0, "rst_hold0");
        drive(32'd7, 32'd9, 1'b0, 1'b0, 33'h0, "rst_hold1");
        drive(32'd7, 32'd9, 1'b0, 1'b1, 33'd16, "rst_release");

        // Back-to-back pipeline.
        drive(32'd1, 32'd2, 1'b0, 1'b1, 33'd3, "b2b_0");
        drive(32'd3, 32'd4, 1'b1, 1'b1, 33'd8, "b2b_1");
        drive(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, {1'b1, 32'h0}, "b2b_2");

        // Mid-stream reset: in-flight result discarded, not seen after release.
        drive(32'd100, 32'd23, 1'b0, 1'b1, 33'd123, "mid_before");
        drive(32'd55, 32'd45, 1'b0, 1'b0, 33'h0, "mid_reset");
        drive(32'd1, 32'd1, 1'b0, 1'b1, 33'd2, "mid_after");

        // Random vectors against a 33-bit behavioural sum.
        for (int n = 0; n < 10000; n++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            drive(ra, rb, rc, 1'b1, {1'b0, ra} + {1'b0, rb} + {32'h0, rc}, "random");
        end

        // Drain: stop issuing, let the last result be checked.
        @(negedge clk);
        drv_vld = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results never presented, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_kogge_stone_32bit
